row_clear_engine: RTL and testbench
===================================

Name: row_clear_engine

Overview:
- Parametrised, sequential successor to the playfield row-check logic.
- Scans a COLS x ROWS occupancy matrix from bottom row to top, one row per cycle.
- Removes every full row by shifting all rows above it down one place, then reports the cleared-row count.
- Sits between the piece-lock logic and the score/display path; start/busy/done handshake.

Parameters:
COLS, 20, cells per row (>=1)
ROWS, 20, rows in playfield (>=2)
CNT_W, 5, width of rows_cleared; must satisfy 2^CNT_W > ROWS

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
matrix_in  input  ROWS*COLS  occupancy; cell (x,y) = bit y*COLS+x; row 0 top, row ROWS-1 bottom
busy  output  1  high from cycle after accepted start until done cycle inclusive
done  output  1  one-cycle pulse, result valid
matrix_out  output  ROWS*COLS  compacted matrix, registered, held until next done
rows_cleared  output  CNT_W  number of rows removed in last operation, held
score_plus  output  CNT_W+1  score increment for last operation, held

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; busy=0, done=0, matrix_out=0, rows_cleared=0, score_plus=0; internal work matrix, row pointer, count cleared. Reset mid-operation aborts with no done pulse.
- States: IDLE, SCAN, FINISH.
- IDLE: start=1 -> work<=matrix_in, ptr<=ROWS-1, cnt<=0, go SCAN. Otherwise stay.
- SCAN, per cycle, examine row ptr of work. A row is full iff all COLS bits are 1.
  - Full: rows 1..ptr <= rows 0..ptr-1; row 0 <= all zero; cnt+1; ptr unchanged. The same row is re-examined next cycle.
  - Not full, ptr>0: ptr-1.
  - Not full, ptr==0: go FINISH.
- FINISH: matrix_out<=work, rows_cleared<=cnt, score_plus per feature, done=1 for this cycle, go IDLE.
- Latency: start accepted at cycle 0 -> done at cycle ROWS+K+1, where K = rows cleared.
- Row 0 full: shifted to empty, re-examined, not full; no special case.
- start while busy or during FINISH: ignored; no queuing. start in the cycle after done: accepted normally.
- matrix_in is sampled only at accept; later changes have no effect.
- cnt never exceeds ROWS; no wrap logic required given CNT_W rule.
- Unused cells above shifted rows fill with 0 only.

Optional Feature:
ROW_CLEAR_BONUS_EN
- Defined: score_plus is weighted by K.
  - K=0->0, 1->1, 2->3, 3->5, 4->8.
  - K>=5 -> 2*K.
  - The mapping is a registered lookup in FINISH.
- Undefined: score_plus = rows_cleared zero-extended to CNT_W+1.
- Latency and all other outputs are identical in both builds.

Test Plan:
- Reset, then idle 5 cycles with start=0 -> busy=0, done never asserts, all outputs 0.
- COLS=4, ROWS=4. Rows top..bottom 0000,0100,1111,0011 -> done at cycle 6. matrix_out rows 0000,0000,0100,0011. rows_cleared=1, score_plus=1.
- COLS=4, ROWS=4, all four rows 1111 -> done at cycle 9. matrix_out=0, rows_cleared=4. score_plus=8 with ROW_CLEAR_BONUS_EN, 4 without.
- Default 20x20, rows 17 and 19 full, row 18 = single bit x=3, rest 0 -> done at cycle 23. Bottom row holds only x=3, rows_cleared=2, score_plus=3 (bonus) / 2.
- Pulse start again at cycles 2 and 5 of a run -> ignored. Single done at the expected cycle; result matches the first matrix_in.
- Assert rst_n=0 mid-SCAN for one cycle -> no done, outputs 0. A following start completes normally.

Source files
------------

// File: rtl/row_clear_engine.sv
// row_clear_engine
// Sequential row-clear pass over a COLS x ROWS occupancy matrix. Rows are
// scanned from the bottom (row ROWS-1) to the top (row 0), one row per cycle.
// A full row is removed by shifting every row above it down one place. The
// same row index is then examined again. When the pass is done, the compacted
// matrix, the cleared-row count and a score increment are presented together
// with a one-cycle done pulse.
//
// Build option: define ROW_CLEAR_BONUS_EN to weight score_plus by the number
// of cleared rows. When it is undefined, score_plus equals rows_cleared.
module row_clear_engine #(
  parameter int COLS  = 20,
  parameter int ROWS  = 20,
  parameter int CNT_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ROWS*COLS-1:0]   matrix_in,
  output logic                   busy,
  output logic                   done,
  output logic [ROWS*COLS-1:0]   matrix_out,
  output logic [CNT_W-1:0]       rows_cleared,
  output logic [CNT_W:0]         score_plus
);

  localparam int MAT_W = ROWS * COLS;
  localparam int PTR_W = $clog2(ROWS);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FINISH
  } state_t;

  state_t             state;
  logic [MAT_W-1:0]   work;
  logic [PTR_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;

  logic               row_full;
  logic [MAT_W-1:0]   low_mask;
  logic [MAT_W-1:0]   shifted;
  int                 keep_bits;

`ifdef ROW_CLEAR_BONUS_EN
  // Weighted score: small clears follow a fixed table, larger ones earn 2*K.
  function automatic logic [CNT_W:0] score_of(input logic [CNT_W-1:0] k);
    case (int'(k))
      0:       return '0;
      1:       return (CNT_W+1)'(1);
      2:       return (CNT_W+1)'(3);
      3:       return (CNT_W+1)'(5);
      4:       return (CNT_W+1)'(8);
      default: return {k, 1'b0};
    endcase
  endfunction
`else
  // Plain score: one point per cleared row.
  function automatic logic [CNT_W:0] score_of(input logic [CNT_W-1:0] k);
    return {1'b0, k};
  endfunction
`endif

  // Full-row test on the current row and the matrix with that row removed.
  // Rows 0..ptr take the row above them (row 0 becomes empty). Rows below ptr
  // are left unchanged.
  always_comb begin
    keep_bits = (int'(ptr) + 1) * COLS;
    low_mask  = ~({MAT_W{1'b1}} << keep_bits);
    shifted   = ((work << COLS) & low_mask) | (work & ~low_mask);
    row_full  = &work[int'(ptr)*COLS +: COLS];
  end

  // Control FSM with registered outputs. The results are loaded on entry to
  // FINISH, so they are already valid in the done cycle.
  // NOTE: every register here uses non-blocking assignment, so all next-state
  // values are computed from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the wide work matrix is reset as well. An aborted pass must
      // leave no stale occupancy behind.
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      matrix_out   <= '0;
      rows_cleared <= '0;
      score_plus   <= '0;
      work         <= '0;
      ptr          <= '0;
      cnt          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work  <= matrix_in;
            ptr   <= PTR_W'(ROWS - 1);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (row_full) begin
            work <= shifted;
            cnt  <= cnt + 1'b1;
          end else if (ptr != '0) begin
            ptr <= ptr - 1'b1;
          end else begin
            matrix_out   <= work;
            rows_cleared <= cnt;
            score_plus   <= score_of(cnt);
            done         <= 1'b1;
            state        <= FINISH;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_clear_engine.sv
// tb_row_clear_engine
// This bench drives two instances: a 4x4 engine (CNT_W=3) and a default
// 20x20 engine. The driver pushes the expected result for every accepted
// start into a per-instance queue. A monitor for each instance pops that queue
// on every done pulse and compares the result. The reference model compacts
// the matrix directly: it keeps the non-full rows in order, drops them to the
// bottom and fills the top with empty rows. Compile with +define+
// ROW_CLEAR_BONUS_EN to check the weighted score build.
module tb_row_clear_engine;

  localparam int SC = 4, SR = 4, SW = 3;
  localparam int LC = 20, LR = 20, LW = 5;

  typedef logic [399:0] mat_t;
  typedef struct {
    mat_t        m;
    int          k;
    int          sp;
    int unsigned done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic                  start_s = 1'b0;
  logic [SR*SC-1:0]      min_s = '0;
  logic                  busy_s, done_s;
  logic [SR*SC-1:0]      mout_s;
  logic [SW-1:0]         rc_s;
  logic [SW:0]           sp_s;

  logic                  start_l = 1'b0;
  logic [LR*LC-1:0]      min_l = '0;
  logic                  busy_l, done_l;
  logic [LR*LC-1:0]      mout_l;
  logic [LW-1:0]         rc_l;
  logic [LW:0]           sp_l;

  row_clear_engine #(.COLS(SC), .ROWS(SR), .CNT_W(SW)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .matrix_in(min_s),
    .busy(busy_s), .done(done_s), .matrix_out(mout_s),
    .rows_cleared(rc_s), .score_plus(sp_s)
  );

  row_clear_engine dut_l (
    .clk(clk), .rst_n(rst_n), .start(start_l), .matrix_in(min_l),
    .busy(busy_l), .done(done_l), .matrix_out(mout_l),
    .rows_cleared(rc_l), .score_plus(sp_l)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q_s[$];
  exp_t q_l[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input mat_t got, input mat_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  function automatic int bonus(input int k);
`ifdef ROW_CLEAR_BONUS_EN
    int table_v[5] = '{0, 1, 3, 5, 8};
    return (k < 5) ? table_v[k] : 2 * k;
`else
    return k;
`endif
  endfunction

  // Keep non-full rows in bottom-to-top order and restack them from the bottom.
  function automatic exp_t model(input mat_t m, input int rows, input int cols);
    exp_t e;
    int   dst;
    bit   full;
    e.m = '0;
    e.k = 0;
    dst = rows - 1;
    for (int y = rows - 1; y >= 0; y--) begin
      full = 1'b1;
      for (int x = 0; x < cols; x++) if (!m[y*cols+x]) full = 1'b0;
      if (full) e.k++;
      else begin
        for (int x = 0; x < cols; x++) e.m[dst*cols+x] = m[y*cols+x];
        dst--;
      end
    end
    e.sp = bonus(e.k);
    e.done_cyc = 0;
    return e;
  endfunction

  function automatic mat_t rand_mat(input bit big);
    mat_t m = '0;
    int rows = big ? LR : SR;
    int cols = big ? LC : SC;
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < cols; x++) begin
        if ($urandom_range(0, 2) == 0) m[y*cols+x] = 1'b1;
      end
      if ($urandom_range(0, 2) == 0)
        for (int x = 0; x < cols; x++) m[y*cols+x] = 1'b1;
    end
    return m;
  endfunction

  task automatic compare(input string tag, input exp_t e, input mat_t got_m,
                         input int got_k, input int got_sp, input logic got_busy);
    check({tag, "_matrix_out"}, got_m, e.m);
    check({tag, "_rows_cleared"}, mat_t'(got_k), mat_t'(e.k));
    check({tag, "_score_plus"}, mat_t'(got_sp), mat_t'(e.sp));
    check({tag, "_done_cycle"}, mat_t'(cyc), mat_t'(e.done_cyc));
    check({tag, "_busy_at_done"}, mat_t'(got_busy), mat_t'(1));
  endtask

  // Monitor, small instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_s) begin
      if (q_s.size() == 0) begin
        n_checks++;
        $display("FAIL s_unexpected_done got=1 exp=0");
      end else begin
        e = q_s.pop_front();
        compare("s", e, mat_t'(mout_s), int'(rc_s), int'(sp_s), busy_s);
      end
    end
  end

  // Monitor, large instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_l) begin
      if (q_l.size() == 0) begin
        n_checks++;
        $display("FAIL l_unexpected_done got=1 exp=0");
      end else begin
        e = q_l.pop_front();
        compare("l", e, mat_t'(mout_l), int'(rc_l), int'(sp_l), busy_l);
      end
    end
  end

  task automatic drive(input bit big, input logic s, input mat_t m);
    if (big) begin start_l = s; min_l = m[LR*LC-1:0]; end
    else     begin start_s = s; min_s = m[SR*SC-1:0]; end
  endtask

  // Wait for idle, then issue one start. The task returns in cycle 1 of the run.
  // With glitch set, start is pulsed again in cycles 2 and 5 of the run.
  task automatic issue(input bit big, input mat_t m, input bit glitch, input bit push);
    int   n = 0;
    exp_t e;
    int   rows = big ? LR : SR;
    int   cols = big ? LC : SC;
    @(negedge clk);
    while ((big ? busy_l : busy_s) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_checks++;
      $display("FAIL idle_wait_timeout got=busy exp=idle");
    end
    e = model(m, rows, cols);
    e.done_cyc = cyc + rows + e.k + 1;
    drive(big, 1'b1, m);
    if (push) begin
      if (big) q_l.push_back(e);
      else     q_s.push_back(e);
    end
    @(negedge clk);
    check("busy_after_accept", mat_t'(big ? busy_l : busy_s), mat_t'(1));
    drive(big, 1'b0, rand_mat(big));
    if (glitch) begin
      @(negedge clk); drive(big, 1'b1, rand_mat(big));
      @(negedge clk); drive(big, 1'b0, rand_mat(big));
      @(negedge clk);
      @(negedge clk); drive(big, 1'b1, rand_mat(big));
      @(negedge clk); drive(big, 1'b0, rand_mat(big));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mat_t m;
    int   n;

    // Reset, then stay idle.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_s", mat_t'({busy_s, done_s, mout_s, rc_s, sp_s}), '0);
      check("idle_l", mat_t'({busy_l, done_l, mout_l, rc_l, sp_l}), '0);
    end

    // 4x4, rows top..bottom 0000,0100,1111,0011.
    m = '0;
    m[15:0] = {4'b0011, 4'b1111, 4'b0100, 4'b0000};
    issue(1'b0, m, 1'b0, 1'b1);

    // 4x4, all rows full.
    m = '0;
    m[15:0] = 16'hFFFF;
    issue(1'b0, m, 1'b0, 1'b1);

    // Ignored start pulses, first on a run with no full rows.
    m = '0;
    m[15:0] = {4'b0111, 4'b1010, 4'b0001, 4'b1000};
    issue(1'b0, m, 1'b1, 1'b1);
    issue(1'b0, rand_mat(1'b0), 1'b1, 1'b1);

    // Random runs issued back-to-back.
    for (int i = 0; i < 30; i++) issue(1'b0, rand_mat(1'b0), 1'b0, 1'b1);

    // Reset in cycle 2 of a run: no done pulse, all outputs cleared.
    issue(1'b0, rand_mat(1'b0), 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_outputs_s", mat_t'({busy_s, done_s, mout_s, rc_s, sp_s}), '0);
    repeat (30) @(negedge clk);
    check("abort_still_idle_s", mat_t'({busy_s, mout_s}), '0);
    issue(1'b0, rand_mat(1'b0), 1'b0, 1'b1);

    // 20x20: rows 17 and 19 are full, row 18 holds only x=3.
    m = '0;
    m[17*LC +: LC] = '1;
    m[19*LC +: LC] = '1;
    m[18*LC + 3]   = 1'b1;
    issue(1'b1, m, 1'b0, 1'b1);
    issue(1'b1, rand_mat(1'b1), 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) issue(1'b1, rand_mat(1'b1), 1'b0, 1'b1);

    // Drain outstanding results.
    n = 0;
    while ((q_s.size() != 0 || q_l.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_s", mat_t'(q_s.size()), '0);
    check("drain_l", mat_t'(q_l.size()), '0);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
